fp_class: RTL and testbench

Pipelined floating-point classify unit (FCLASS.S / FCLASS.D) for the float execute stage. It decomposes an FP register operand into its sign, exponent and mantissa fields and returns the standard 10-bit one-hot class mask. The sign-injection unit composes a result from field pieces; this block performs the reverse operation and takes operands apart. It sits beside the other float EX units, behind a valid/ready handshake, and carries a destination tag through its 2-stage pipeline.

---
 rtl/fp_class_if.sv | 42 ++++
 rtl/fp_class.sv | 145 ++++++++++++++
 tb/tb_fp_class.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_class_if.sv
// Operand/result handshake bundle for the fp_class unit.
// The slave modport is the unit's view; the master modport is the issuing/consuming side.
interface fp_class_if #(
  parameter int TAG_W = 5
);
  logic             fp_class_i_valid;
  logic             fp_class_o_ready;
  logic [63:0]      fp_class_i_data;
  logic [1:0]       fp_class_i_fmt;
  logic [TAG_W-1:0] fp_class_i_tag;
  logic             fp_class_o_valid;
  logic             fp_class_i_ready;
  logic [63:0]      fp_class_o_result;
  logic [TAG_W-1:0] fp_class_o_tag;
  logic             fp_class_o_err;

  modport slave (
    input  fp_class_i_valid,
    input  fp_class_i_data,
    input  fp_class_i_fmt,
    input  fp_class_i_tag,
    input  fp_class_i_ready,
    output fp_class_o_ready,
    output fp_class_o_valid,
    output fp_class_o_result,
    output fp_class_o_tag,
    output fp_class_o_err
  );

  modport master (
    output fp_class_i_valid,
    output fp_class_i_data,
    output fp_class_i_fmt,
    output fp_class_i_tag,
    output fp_class_i_ready,
    input  fp_class_o_ready,
    input  fp_class_o_valid,
    input  fp_class_o_result,
    input  fp_class_o_tag,
    input  fp_class_o_err
  );
endinterface

// File: rtl/fp_class.sv
// Two-stage elastic FCLASS.S/FCLASS.D unit: S1 splits the operand into field flags, S2 forms the one-hot mask.
// Optional macro FP_CLASS_NANBOX_EN: single operands that are not NaN-boxed classify as quiet NaN.
module fp_class #(
  parameter int TAG_W = 5
) (
  input  logic     fp_class_i_clk,
  input  logic     fp_class_i_rst_n,
  fp_class_if.slave bus
);

  logic [63:0]      opData;
  logic             decSign, decExpOnes, decExpZero, decManZero, decManMsb, decIllegal;

  logic             s1Valid_q, s1Valid_d;
  logic             s1Sign_q, s1Sign_d;
  logic             s1ExpOnes_q, s1ExpOnes_d;
  logic             s1ExpZero_q, s1ExpZero_d;
  logic             s1ManZero_q, s1ManZero_d;
  logic             s1ManMsb_q, s1ManMsb_d;
  logic             s1Illegal_q, s1Illegal_d;
  logic [TAG_W-1:0] s1Tag_q, s1Tag_d;

  logic             s2Valid_q, s2Valid_d;
  logic [9:0]       s2Mask_q, s2Mask_d;
  logic             s2Err_q, s2Err_d;
  logic [TAG_W-1:0] s2Tag_q, s2Tag_d;

  logic [9:0]       maskC;
  logic             s2Adv, s1Adv, inFire;

  assign opData = bus.fp_class_i_data;

  assign s2Adv  = !s2Valid_q || bus.fp_class_i_ready;
  assign s1Adv  = !s1Valid_q || s2Adv;
  assign inFire = bus.fp_class_i_valid && s1Adv;

  always_comb begin
    decSign    = opData[63];
    decExpOnes = &opData[62:52];
    decExpZero = ~|opData[62:52];
    decManZero = ~|opData[51:0];
    decManMsb  = opData[51];
    decIllegal = bus.fp_class_i_fmt[1];
    if (bus.fp_class_i_fmt == 2'd0) begin
      decSign    = opData[31];
      decExpOnes = &opData[30:23];
      decExpZero = ~|opData[30:23];
      decManZero = ~|opData[22:0];
      decManMsb  = opData[22];
`ifdef FP_CLASS_NANBOX_EN
      // An improperly boxed single reads as the canonical quiet NaN.
      if (opData[63:32] != 32'hFFFF_FFFF) begin
        decExpOnes = 1'b1;
        decExpZero = 1'b0;
        decManZero = 1'b0;
        decManMsb  = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    maskC = '0;
    if (!s1Illegal_q) begin
      maskC[0] =  s1Sign_q &  s1ExpOnes_q &  s1ManZero_q;
      maskC[1] =  s1Sign_q & ~s1ExpOnes_q & ~s1ExpZero_q;
      maskC[2] =  s1Sign_q &  s1ExpZero_q & ~s1ManZero_q;
      maskC[3] =  s1Sign_q &  s1ExpZero_q &  s1ManZero_q;
      maskC[4] = ~s1Sign_q &  s1ExpZero_q &  s1ManZero_q;
      maskC[5] = ~s1Sign_q &  s1ExpZero_q & ~s1ManZero_q;
      maskC[6] = ~s1Sign_q & ~s1ExpOnes_q & ~s1ExpZero_q;
      maskC[7] = ~s1Sign_q &  s1ExpOnes_q &  s1ManZero_q;
      maskC[8] =  s1ExpOnes_q & ~s1ManZero_q & ~s1ManMsb_q;
      maskC[9] =  s1ExpOnes_q &  s1ManMsb_q;
    end
  end

  // Stage contents change only on a transfer into that stage, so stalled data stays put.
  always_comb begin
    s1Valid_d   = s1Adv ? bus.fp_class_i_valid : s1Valid_q;
    s1Sign_d    = s1Sign_q;
    s1ExpOnes_d = s1ExpOnes_q;
    s1ExpZero_d = s1ExpZero_q;
    s1ManZero_d = s1ManZero_q;
    s1ManMsb_d  = s1ManMsb_q;
    s1Illegal_d = s1Illegal_q;
    s1Tag_d     = s1Tag_q;
    if (inFire) begin
      s1Sign_d    = decSign;
      s1ExpOnes_d = decExpOnes;
      s1ExpZero_d = decExpZero;
      s1ManZero_d = decManZero;
      s1ManMsb_d  = decManMsb;
      s1Illegal_d = decIllegal;
      s1Tag_d     = bus.fp_class_i_tag;
    end
    s2Valid_d = s2Adv ? s1Valid_q : s2Valid_q;
    s2Mask_d  = s2Mask_q;
    s2Err_d   = s2Err_q;
    s2Tag_d   = s2Tag_q;
    if (s2Adv && s1Valid_q) begin
      s2Mask_d = maskC;
      s2Err_d  = s1Illegal_q;
      s2Tag_d  = s1Tag_q;
    end
  end

  always_ff @(posedge fp_class_i_clk or negedge fp_class_i_rst_n) begin
    if (!fp_class_i_rst_n) begin
      s1Valid_q   <= 1'b0;
      s1Sign_q    <= 1'b0;
      s1ExpOnes_q <= 1'b0;
      s1ExpZero_q <= 1'b0;
      s1ManZero_q <= 1'b0;
      s1ManMsb_q  <= 1'b0;
      s1Illegal_q <= 1'b0;
      s1Tag_q     <= '0;
      s2Valid_q   <= 1'b0;
      s2Mask_q    <= '0;
      s2Err_q     <= 1'b0;
      s2Tag_q     <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Sign_q    <= s1Sign_d;
      s1ExpOnes_q <= s1ExpOnes_d;
      s1ExpZero_q <= s1ExpZero_d;
      s1ManZero_q <= s1ManZero_d;
      s1ManMsb_q  <= s1ManMsb_d;
      s1Illegal_q <= s1Illegal_d;
      s1Tag_q     <= s1Tag_d;
      s2Valid_q   <= s2Valid_d;
      s2Mask_q    <= s2Mask_d;
      s2Err_q     <= s2Err_d;
      s2Tag_q     <= s2Tag_d;
    end
  end

  // Ready is forced low while reset is held, even though the empty pipe would otherwise accept.
  assign bus.fp_class_o_ready  = fp_class_i_rst_n && s1Adv;
  assign bus.fp_class_o_valid  = s2Valid_q;
  assign bus.fp_class_o_result = {54'd0, s2Mask_q};
  assign bus.fp_class_o_tag    = s2Tag_q;
  assign bus.fp_class_o_err    = s2Err_q;

endmodule

// File: tb/tb_fp_class.sv
// Randomized self-checking bench for fp_class: operands are classified by a field-level reference
// model and matched in order against results through a scoreboard queue.
module tb_fp_class;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  fmt;
    logic [4:0]  tag;
    bit          hasWant;
    logic [9:0]  want;
  } opT;

  typedef struct {
    logic [9:0] mask;
    logic [4:0] tag;
    logic       err;
    int         cyc;
  } expT;

  logic clk = 1'b0;
  logic rst_n;

  fp_class_if #(.TAG_W(5)) bus ();

  fp_class #(.TAG_W(5)) dut (
    .fp_class_i_clk  (clk),
    .fp_class_i_rst_n(rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  opT          pendQ[$];
  expT         expQ[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acceptCnt = 0;
  int          outCnt = 0;
  bit          latChk = 1'b0;
  bit          prevStall = 1'b0;
  logic [63:0] prevRes;
  logic [4:0]  prevTag;
  logic        prevErr;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference classification straight from the IEEE-754 field meanings.
  function automatic logic [9:0] refClass(input logic [63:0] d, input logic [1:0] fmt);
    int          expVal, expMax, idx;
    logic [63:0] man;
    bit          neg, quiet;
    if (fmt > 2'd1) return 10'd0;
    if (fmt == 2'd0) begin
`ifdef FP_CLASS_NANBOX_EN
      if (d[63:32] != 32'hFFFF_FFFF) return 10'h200;
`endif
      neg = d[31]; expVal = int'(d[30:23]); expMax = 255;
      man = {41'd0, d[22:0]}; quiet = d[22];
    end else begin
      neg = d[63]; expVal = int'(d[62:52]); expMax = 2047;
      man = {12'd0, d[51:0]}; quiet = d[51];
    end
    if (expVal == expMax) begin
      if (man == 64'd0) idx = neg ? 0 : 7;
      else              idx = quiet ? 9 : 8;
    end else if (expVal == 0) begin
      if (man == 64'd0) idx = neg ? 3 : 4;
      else              idx = neg ? 2 : 5;
    end else begin
      idx = neg ? 1 : 6;
    end
    return 10'b1 << idx;
  endfunction

  function automatic opT randOp();
    opT          op;
    int          kind;
    logic [63:0] r;
    logic [10:0] e11;
    logic [51:0] m52;
    logic [7:0]  e8;
    logic [22:0] m23;
    logic [31:0] upper;
    logic        sgn;
    kind = $urandom_range(0, 5);
    op.fmt = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    sgn = 1'($urandom);
    r = {$urandom(), $urandom()};
    m52 = r[51:0];
    if (m52 == 52'd0) m52 = 52'd1;
    m23 = r[22:0];
    if (m23 == 23'd0) m23 = 23'd1;
    case (kind)
      0: begin e11 = 11'd0;     m52 = '0;  e8 = 8'd0;    m23 = '0;  end
      1: begin e11 = 11'd0;                e8 = 8'd0;               end
      2: begin e11 = 11'($urandom_range(1, 2046)); e8 = 8'($urandom_range(1, 254)); end
      3: begin e11 = 11'h7FF;   m52 = '0;  e8 = 8'hFF;   m23 = '0;  end
      4: begin e11 = 11'h7FF;              e8 = 8'hFF;              end
      default: begin e11 = r[62:52]; e8 = r[30:23]; end
    endcase
    upper = ($urandom_range(0, 9) == 0) ? $urandom() : 32'hFFFF_FFFF;
    if (op.fmt == 2'd0) op.data = {upper, sgn, e8, m23};
    else                op.data = {sgn, e11, m52};
    if (kind == 5) op.data = {$urandom(), $urandom()};
    op.tag = 5'($urandom);
    op.hasWant = 1'b0;
    op.want = '0;
    return op;
  endfunction

  task automatic pushOp(input logic [63:0] data, input logic [1:0] fmt, input logic [4:0] tag,
                        input logic [9:0] want);
    opT op;
    op.data = data; op.fmt = fmt; op.tag = tag; op.hasWant = 1'b1; op.want = want;
    pendQ.push_back(op);
  endtask

  // One clock cycle: drive at the falling edge, sample just after, book-keep transfers.
  task automatic applyStimulus(input bit offer, input bit iReady);
    bit  acc, outx;
    opT  op;
    expT e;
    @(negedge clk);
    bus.fp_class_i_ready = iReady;
    if (offer && pendQ.size() > 0) begin
      op = pendQ[0];
      bus.fp_class_i_valid = 1'b1;
      bus.fp_class_i_data  = op.data;
      bus.fp_class_i_fmt   = op.fmt;
      bus.fp_class_i_tag   = op.tag;
    end else begin
      bus.fp_class_i_valid = 1'b0;
      bus.fp_class_i_data  = {$urandom(), $urandom()};
      bus.fp_class_i_fmt   = 2'($urandom);
      bus.fp_class_i_tag   = 5'($urandom);
    end
    #1;
    if (prevStall) begin
      checkOutput("hold_valid", 64'(bus.fp_class_o_valid), 64'd1);
      checkOutput("hold_result", bus.fp_class_o_result, prevRes);
      checkOutput("hold_tag", 64'(bus.fp_class_o_tag), 64'(prevTag));
      checkOutput("hold_err", 64'(bus.fp_class_o_err), 64'(prevErr));
    end
    acc  = bus.fp_class_i_valid && bus.fp_class_o_ready;
    outx = bus.fp_class_o_valid && iReady;
    if (outx) begin
      outCnt++;
      if (expQ.size() == 0) begin
        checkOutput("spurious_result", 64'd1, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", bus.fp_class_o_result, 64'(e.mask));
        checkOutput("tag", 64'(bus.fp_class_o_tag), 64'(e.tag));
        checkOutput("err", 64'(bus.fp_class_o_err), 64'(e.err));
        if (latChk) checkOutput("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    prevStall = bus.fp_class_o_valid && !iReady;
    prevRes   = bus.fp_class_o_result;
    prevTag   = bus.fp_class_o_tag;
    prevErr   = bus.fp_class_o_err;
    if (acc) begin
      op = pendQ.pop_front();
      e.mask = op.hasWant ? op.want : refClass(op.data, op.fmt);
      e.tag  = op.tag;
      e.err  = (op.fmt > 2'd1);
      e.cyc  = cyc;
      expQ.push_back(e);
      acceptCnt++;
    end
    cyc++;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ready"}, 64'(bus.fp_class_o_ready), 64'd0);
    checkOutput({name, "_valid"}, 64'(bus.fp_class_o_valid), 64'd0);
    checkOutput({name, "_result"}, bus.fp_class_o_result, 64'd0);
    checkOutput({name, "_tag"}, 64'(bus.fp_class_o_tag), 64'd0);
    checkOutput({name, "_err"}, 64'(bus.fp_class_o_err), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    logic [9:0] boxWant;

    // Reset held with an operand on offer: every output stays at zero.
    rst_n = 1'b0;
    bus.fp_class_i_valid = 1'b1;
    bus.fp_class_i_data  = 64'hFFFF_FFFF_3F80_0000;
    bus.fp_class_i_fmt   = 2'd0;
    bus.fp_class_i_tag   = 5'h1F;
    bus.fp_class_i_ready = 1'b1;
    #3;
    checkAllZero("reset");
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset_held");
    @(negedge clk);
    bus.fp_class_i_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 64'(bus.fp_class_o_ready), 64'd1);
    checkOutput("valid_after_reset", 64'(bus.fp_class_o_valid), 64'd0);

    // Single-precision directed operands.
    latChk = 1'b1;
    pushOp(64'hFFFF_FFFF_3F80_0000, 2'd0, 5'd3, 10'h040);
    pushOp(64'hFFFF_FFFF_7F80_0001, 2'd0, 5'd4, 10'h100);
    pushOp(64'hFFFF_FFFF_8000_0001, 2'd0, 5'd5, 10'h004);
    repeat (6) applyStimulus(1'b1, 1'b1);

    // Double-precision back-to-back stream.
    pushOp(64'hFFF0_0000_0000_0000, 2'd1, 5'd10, 10'h001);
    pushOp(64'h7FF8_0000_0000_0000, 2'd1, 5'd11, 10'h200);
    pushOp(64'h0000_0000_0000_0000, 2'd1, 5'd12, 10'h010);
    pushOp(64'h8000_0000_0000_0000, 2'd1, 5'd13, 10'h008);
    repeat (7) applyStimulus(1'b1, 1'b1);

    // NaN-boxing and illegal format.
`ifdef FP_CLASS_NANBOX_EN
    boxWant = 10'h200;
`else
    boxWant = 10'h040;
`endif
    pushOp(64'h0000_0000_3F80_0000, 2'd0, 5'd20, boxWant);
    pushOp(64'h0000_0000_3F80_0000, 2'd2, 5'd21, 10'h000);
    pushOp(64'hFFFF_FFFF_0000_0000, 2'd0, 5'd22, 10'h010);
    repeat (6) applyStimulus(1'b1, 1'b1);
    latChk = 1'b0;
    checkOutput("directed_drained", 64'(expQ.size()), 64'd0);

    // Backpressure: four offered, only two fit.
    pushOp(64'hFFFF_FFFF_0000_0001, 2'd0, 5'd1, 10'h020);
    pushOp(64'hFFFF_FFFF_FF80_0000, 2'd0, 5'd2, 10'h001);
    pushOp(64'h3FF0_0000_0000_0000, 2'd1, 5'd6, 10'h040);
    pushOp(64'h7FF0_0000_0000_0001, 2'd1, 5'd7, 10'h100);
    acc0 = acceptCnt;
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("bp_accepted", 64'(acceptCnt - acc0), 64'd2);
    checkOutput("bp_ready_low", 64'(bus.fp_class_o_ready), 64'd0);
    repeat (8) applyStimulus(1'b1, 1'b1);
    checkOutput("bp_pending_empty", 64'(pendQ.size()), 64'd0);
    checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

    // Randomized traffic with random valid and ready.
    for (int i = 0; i < 600; i++) begin
      if (pendQ.size() < 3) pendQ.push_back(randOp());
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rand_pending_empty", 64'(pendQ.size()), 64'd0);
    checkOutput("rand_drained", 64'(expQ.size()), 64'd0);
    checkOutput("in_out_count", 64'(outCnt), 64'(acceptCnt));

    // Reset while two operands are in flight.
    pushOp(64'hFFFF_FFFF_3F80_0000, 2'd0, 5'd8, 10'h040);
    pushOp(64'h7FF8_0000_0000_0000, 2'd1, 5'd9, 10'h200);
    repeat (2) applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    bus.fp_class_i_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    expQ.delete();
    pendQ.delete();
    prevStall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.fp_class_i_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_reset_valid", 64'(bus.fp_class_o_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
